// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, stall patterns,
// stage bit indices and the stall-priority helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } pc_state_e;

    localparam int NUM_STG = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic [NUM_STG-1:0] STALL_NONE  = 6'b000000;
    localparam logic [NUM_STG-1:0] STALL_ID    = 6'b000111;
    localparam logic [NUM_STG-1:0] STALL_EX    = 6'b001111;
    localparam logic [NUM_STG-1:0] STALL_MEM   = 6'b011111;
    localparam logic [NUM_STG-1:0] STALL_DRAIN = 6'b000011;

    // The deepest requesting stage freezes itself and everything upstream of it.
    function automatic logic [NUM_STG-1:0] stall_prio(input logic ds, input logic es,
                                                     input logic ms);
        if (ms)      return STALL_MEM;
        else if (es) return STALL_EX;
        else if (ds) return STALL_ID;
        else         return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Controller <-> pipeline signal bundle. master = controller, slave = stages.
// Perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                stallreq_ds;
    logic                stallreq_es;
    logic                stallreq_ms;
    logic                ws_excp;
    logic                ws_ertn;
    logic [31:0]         excp_entry;
    logic [31:0]         csr_era;
    logic                fetch_pending;
    logic [NUM_STG-1:0]  stall;
    logic                flush;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]         perf_stall_cycles;
    logic [31:0]         perf_flush_cnt;
`endif

    modport master (
        input  stallreq_ds, stallreq_es, stallreq_ms, ws_excp, ws_ertn,
               excp_entry, csr_era, fetch_pending,
`ifdef PIPE_CTRL_PERF_EN
        output perf_stall_cycles, perf_flush_cnt,
`endif
        output stall, flush, redirect_valid, redirect_pc, stall_timeout
    );

    modport slave (
        output stallreq_ds, stallreq_es, stallreq_ms, ws_excp, ws_ertn,
               excp_entry, csr_era, fetch_pending,
`ifdef PIPE_CTRL_PERF_EN
        input  perf_stall_cycles, perf_flush_cnt,
`endif
        input  stall, flush, redirect_valid, redirect_pc, stall_timeout
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Saturating count of consecutive stalled RUN cycles with a sticky timeout flag.
module pipe_stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic i_stalled,
    input  logic i_clr,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STALL_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (i_clr)
                r_cnt <= '0;
            else if (i_stalled && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;

            // Counter already shows TIMEOUT-1 completed cycles; this is the next one.
            if (i_stalled && (r_cnt == LP_LAST))
                r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, exception/ertn flush + redirect, post-flush
// fetch drain, stall watchdog. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic           clk,
    input  logic           reset,
    pipe_ctrl_if.master    bus
);

    pc_state_e           r_state;
    pc_state_e           w_next;
    logic [NUM_STG-1:0]  w_stall;
    logic [NUM_STG-1:0]  w_req_stall;
    logic                w_go_flush;
    logic                w_wd_stalled;
    logic                w_wd_clr;
    logic                r_flush;
    logic                r_redir_vld;
    logic [31:0]         r_redir_pc;

    assign w_req_stall = stall_prio(bus.stallreq_ds, bus.stallreq_es, bus.stallreq_ms);
    // Commit pulses are only honoured in RUN; the pipeline is already empty otherwise.
    assign w_go_flush  = (r_state == RUN) && (bus.ws_excp || bus.ws_ertn);

    always_comb begin
        w_next  = r_state;
        w_stall = STALL_NONE;
        case (r_state)
            RUN: begin
                w_stall = w_req_stall;
                if (w_go_flush) w_next = FLUSH;
            end
            FLUSH: begin
                w_next = bus.fetch_pending ? DRAIN : RUN;
            end
            DRAIN: begin
                w_stall = STALL_DRAIN;
                if (!bus.fetch_pending) w_next = RUN;
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_flush     <= 1'b0;
            r_redir_vld <= 1'b0;
            r_redir_pc  <= 32'h0;
        end else begin
            r_state     <= w_next;
            r_flush     <= w_go_flush;
            r_redir_vld <= w_go_flush;
            if (w_go_flush)
                r_redir_pc <= bus.ws_excp ? bus.excp_entry : bus.csr_era;
        end
    end

    assign w_wd_stalled = (r_state == RUN) && (w_stall != STALL_NONE);
    assign w_wd_clr     = w_go_flush || ((r_state == RUN) && (w_stall == STALL_NONE));

    pipe_stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_wd (
        .clk       (clk),
        .reset     (reset),
        .i_stalled (w_wd_stalled),
        .i_clr     (w_wd_clr),
        .o_timeout (bus.stall_timeout)
    );

    assign bus.stall          = w_stall;
    assign bus.flush          = r_flush;
    assign bus.redirect_valid = r_redir_vld;
    assign bus.redirect_pc    = r_redir_pc;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall <= 32'h0;
            r_perf_flush <= 32'h0;
        end else begin
            if (w_stall != STALL_NONE) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_go_flush)            r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = r_perf_stall;
    assign bus.perf_flush_cnt    = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STALL_TIMEOUT=8): priority, redirect, drain,
// watchdog and async reset, with hand-computed expectations.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .STALL_TIMEOUT (8),
        .CNT_W         (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Commit pulses are illegal while flushing or draining.
    always @(posedge clk) begin
        if (!reset && (bus.flush || bus.stall == STALL_DRAIN) && (bus.ws_excp || bus.ws_ertn))
            $error("illegal ws_excp/ws_ertn during flush/drain");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.stallreq_ds   = 1'b0;
        bus.stallreq_es   = 1'b0;
        bus.stallreq_ms   = 1'b0;
        bus.ws_excp       = 1'b0;
        bus.ws_ertn       = 1'b0;
        bus.excp_entry    = 32'h0;
        bus.csr_era       = 32'h0;
        bus.fetch_pending = 1'b0;
        ticks(2);

        chk("rst_stall",   32'(bus.stall),          32'h0);
        chk("rst_flush",   32'(bus.flush),          32'h0);
        chk("rst_rv",      32'(bus.redirect_valid), 32'h0);
        chk("rst_rpc",     bus.redirect_pc,         32'h0);
        chk("rst_timeout", 32'(bus.stall_timeout),  32'h0);

        reset = 1'b0;
        tick();

        // Request priority, purely combinational
        bus.stallreq_ds = 1'b1; #1;
        chk("prio_ds", 32'(bus.stall), 32'h07);
        bus.stallreq_es = 1'b1; #1;
        chk("prio_es", 32'(bus.stall), 32'h0F);
        bus.stallreq_ms = 1'b1; #1;
        chk("prio_ms", 32'(bus.stall), 32'h1F);
        bus.stallreq_ds = 1'b0; bus.stallreq_es = 1'b0; bus.stallreq_ms = 1'b0; #1;
        chk("prio_none", 32'(bus.stall), 32'h00);
        tick();

        // Exception redirect, no drain
        bus.excp_entry = 32'h1C008000;
        bus.csr_era    = 32'h1C000100;
        bus.ws_excp    = 1'b1;
        tick();
        bus.ws_excp = 1'b0;
        chk("exc_flush", 32'(bus.flush),          32'h1);
        chk("exc_rv",    32'(bus.redirect_valid), 32'h1);
        chk("exc_rpc",   bus.redirect_pc,         32'h1C008000);
        chk("exc_stall", 32'(bus.stall),          32'h0);
        tick();
        chk("exc_t2_flush", 32'(bus.flush),          32'h0);
        chk("exc_t2_rv",    32'(bus.redirect_valid), 32'h0);
        bus.stallreq_ds = 1'b1; #1;
        chk("exc_t2_run", 32'(bus.stall), 32'h07);
        bus.stallreq_ds = 1'b0;
        tick();

        // ertn alone selects ERA
        bus.ws_ertn = 1'b1;
        tick();
        bus.ws_ertn = 1'b0;
        chk("ertn_rpc", bus.redirect_pc, 32'h1C000100);
        tick();

        // Simultaneous excp+ertn with a three-cycle drain
        bus.ws_excp = 1'b1; bus.ws_ertn = 1'b1; bus.fetch_pending = 1'b1;
        tick();
        bus.ws_excp = 1'b0; bus.ws_ertn = 1'b0;
        chk("both_rpc",   bus.redirect_pc,  32'h1C008000);
        chk("both_flush", 32'(bus.flush),   32'h1);
        tick();
        chk("drain1_stall", 32'(bus.stall), 32'h03);
        chk("drain1_flush", 32'(bus.flush), 32'h0);
        tick();
        chk("drain2_stall", 32'(bus.stall), 32'h03);
        bus.stallreq_es = 1'b1; #1;
        chk("drain2_ignore", 32'(bus.stall), 32'h03);
        bus.stallreq_es = 1'b0;
        tick();
        bus.fetch_pending = 1'b0; #1;
        chk("drain3_stall", 32'(bus.stall), 32'h03);
        tick();
        chk("drain_run", 32'(bus.stall), 32'h00);

        // Stall requests masked across flush/drain
        bus.stallreq_ms = 1'b1; #1;
        chk("ign_pre", 32'(bus.stall), 32'h1F);
        bus.ws_excp = 1'b1; bus.fetch_pending = 1'b1;
        tick();
        bus.ws_excp = 1'b0;
        chk("ign_flush", 32'(bus.stall), 32'h00);
        tick();
        bus.fetch_pending = 1'b0; #1;
        chk("ign_drain", 32'(bus.stall), 32'h03);
        tick();
        chk("ign_run", 32'(bus.stall), 32'h1F);
        bus.stallreq_ms = 1'b0;
        ticks(2);

        // Watchdog: 7 stalled cycles is just under the limit
        bus.stallreq_es = 1'b1;
        ticks(7);
        bus.stallreq_es = 1'b0;
        ticks(2);
        chk("wd7_timeout", 32'(bus.stall_timeout), 32'h0);

        bus.stallreq_es = 1'b1;
        ticks(7);
        chk("wd_at7", 32'(bus.stall_timeout), 32'h0);
        tick();
        chk("wd_at8", 32'(bus.stall_timeout), 32'h1);
        tick();
        bus.stallreq_es = 1'b0;
        ticks(3);
        chk("wd_sticky", 32'(bus.stall_timeout), 32'h1);

        // Async reset while draining
        bus.ws_excp = 1'b1; bus.fetch_pending = 1'b1;
        tick();
        bus.ws_excp = 1'b0;
        tick();
        chk("rd_pre", 32'(bus.stall), 32'h03);
        #2 reset = 1'b1;
        #1;
        chk("rd_stall",   32'(bus.stall),          32'h0);
        chk("rd_flush",   32'(bus.flush),          32'h0);
        chk("rd_rv",      32'(bus.redirect_valid), 32'h0);
        chk("rd_rpc",     bus.redirect_pc,         32'h0);
        chk("rd_timeout", 32'(bus.stall_timeout),  32'h0);
        tick();
        reset = 1'b0;
        bus.fetch_pending = 1'b0;
        tick();
        chk("rd_post_flush", 32'(bus.flush), 32'h0);
        bus.stallreq_ds = 1'b1; #1;
        chk("rd_post_run", 32'(bus.stall), 32'h07);
        bus.stallreq_ds = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
